// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed BCD 7-segment scanner with a tear-free frame buffer.
// Optional leading-zero blanking is built when SEG_LZB_EN is defined.
module seg7_scan_ctrl #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned DIV       = 1000,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                load,
    input  logic [4*DIGITS-1:0] digits_in,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an,
    output logic                frame_done
);

    localparam int unsigned DW = 4 * DIGITS;
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLAST = CW'((BLANK_CYC == 0) ? 32'd0 : BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam state_t SLOT_START = (BLANK_CYC == 0) ? SHOW : BLANK;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [IW-1:0]     idx, idx_n, idx_inc;
    logic [DW-1:0]     shadow, shadow_n;
    logic [DW-1:0]     pending, pending_n;
    logic              pending_valid, pending_valid_n;
    logic [6:0]        seg_n;
    logic [DIGITS-1:0] an_n, an_sel, lzb;
    logic              frame_done_n;
    logic [3:0]        cur_digit;
    logic              cur_blank;
    logic              boundary;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0110111;
        endcase
    endfunction

`ifdef SEG_LZB_EN
    logic lead;

    // Zeros above the highest nonzero digit are blanked; digit 0 always shows.
    always_comb begin
        lead = 1'b1;
        lzb  = '0;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            lead   = lead && (shadow[4*k +: 4] == 4'd0);
            lzb[k] = lead && (k != 0);
        end
    end
`else
    assign lzb = '0;
`endif

    // Select the digit, its blanking flag and its anode for the current slot.
    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        an_sel    = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (idx == IW'(k)) begin
                cur_digit = shadow[4*k +: 4];
                cur_blank = lzb[k];
                an_sel[k] = 1'b1;
            end
        end
    end

    assign idx_inc  = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    assign boundary = enable && (state == SHOW) && (cnt == CNT_LAST) && (idx == IDX_LAST);

    // Next-state, counters, frame buffers and next output values.
    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        idx_n           = idx;
        shadow_n        = shadow;
        pending_n       = pending;
        pending_valid_n = pending_valid;
        seg_n           = '0;
        an_n            = '0;
        frame_done_n    = boundary;

        if (load) begin
            pending_n       = digits_in;
            pending_valid_n = 1'b1;
        end

        if (!enable) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = SLOT_START;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
                BLANK: begin
                    cnt_n = cnt + CW'(1);
                    if (cnt == CNT_BLAST) state_n = SHOW;
                end
                SHOW: begin
                    an_n  = an_sel;
                    seg_n = cur_blank ? 7'd0 : decode(cur_digit);
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        idx_n   = idx_inc;
                        state_n = SLOT_START;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        // Shadow only changes while idle or exactly at a frame boundary.
        if ((state == IDLE) || boundary) begin
            if (load)               shadow_n = digits_in;
            else if (pending_valid) shadow_n = pending;
            pending_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            shadow        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            seg           <= '0;
            an            <= '0;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            idx           <= idx_n;
            shadow        <= shadow_n;
            pending       <= pending_n;
            pending_valid <= pending_valid_n;
            seg           <= seg_n;
            an            <= an_n;
            frame_done    <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIGITS=4, DIV=8, BLANK_CYC=2.
// Expected scan timing comes from a cycle-count model of the slot/frame schedule.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Bench model of the displayed frame, pending buffer and scan position.
    logic [15:0] sh = '0;
    logic [15:0] pend = '0;
    logic        pv = 1'b0;
    logic        in_idle = 1'b1;
    int          cyc = 0;

    seg7_scan_ctrl #(.DIGITS(4), .DIV(8), .BLANK_CYC(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'h0:    return 7'b1111110;
            4'h1:    return 7'b0110000;
            4'h2:    return 7'b1101101;
            4'h3:    return 7'b1111001;
            4'h4:    return 7'b0110011;
            4'h5:    return 7'b1011011;
            4'h6:    return 7'b1011111;
            4'h7:    return 7'b1110000;
            4'h8:    return 7'b1111111;
            4'h9:    return 7'b1111011;
            default: return 7'b0110111;
        endcase
    endfunction

    function automatic logic [6:0] exp_digit(input int d);
        logic [15:0] s;
        s = sh;
`ifdef SEG_LZB_EN
        if (d != 0 && (s >> (4*d)) == 16'd0) return 7'd0;
`endif
        return seg_of(s[4*d +: 4]);
    endfunction

    // One clock with the given inputs; check outputs, then advance the model.
    task automatic step(input logic en, input logic ld, input logic [15:0] val);
        int         c;
        int         d;
        logic [6:0] es;
        logic [3:0] ea;
        logic       ef;
        enable    = en;
        load      = ld;
        digits_in = val;
        @(posedge clk);
        #1;
        load = 1'b0;
        c  = in_idle ? 1 : cyc + 1;
        es = '0;
        ea = '0;
        ef = 1'b0;
        if (en && !in_idle) begin
            d = ((c - 2) / 8) % 4;
            if (c >= 2 && ((c - 2) % 8) >= 2) begin
                ea = 4'(1 << d);
                es = exp_digit(d);
            end
            ef = (c > 1) && (c % 32 == 1);
        end
        cyc = c;
        check("an", 32'(an), 32'(ea));
        check("seg", 32'(seg), 32'(es));
        check("frame_done", 32'(frame_done), 32'(ef));
        if (in_idle || ef) begin
            if (ld)      sh = val;
            else if (pv) sh = pend;
            pv = 1'b0;
        end else if (ld) begin
            pend = val;
            pv   = 1'b1;
        end
        in_idle = !en;
        if (!en) cyc = 0;
    endtask

    initial begin
        int          nc;
        logic [15:0] v;
        logic        ld;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_seg", 32'(seg), 32'd0);
        check("rst_an", 32'(an), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        rst_n = 1'b1;

        // Scan order, tear-free update, load at boundary, last-load-wins, 'H' code
        step(1'b0, 1'b1, 16'h1234);
        while (cyc < 197) begin
            nc = cyc + 1;
            ld = 1'b1;
            case (nc)
                46:      v = 16'h5678;
                70:      v = 16'h1111;
                97:      v = 16'h9999;
                100:     v = 16'h3333;
                105:     v = 16'h4444;
                175:     v = 16'h000A;
                default: begin v = 16'h0000; ld = 1'b0; end
            endcase
            step(1'b1, ld, v);
        end

        // Enable drop mid-slot, then restart from digit 0
        repeat (3) step(1'b0, 1'b0, 16'h0000);
        repeat (40) step(1'b1, 1'b0, 16'h0000);

        // Leading-zero frames (blanked only when SEG_LZB_EN is defined)
        step(1'b0, 1'b1, 16'h0050);
        step(1'b0, 1'b0, 16'h0000);
        repeat (34) step(1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        repeat (34) step(1'b1, 1'b0, 16'h0000);

        // Asynchronous reset mid-SHOW with a pending buffer that must be discarded
        step(1'b1, 1'b1, 16'h7777);
        repeat (2) step(1'b1, 1'b0, 16'h0000);
        check("pre_rst_an", 32'(an), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_seg", 32'(seg), 32'd0);
        check("async_rst_an", 32'(an), 32'd0);
        check("async_rst_fd", 32'(frame_done), 32'd0);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        sh      = '0;
        pend    = '0;
        pv      = 1'b0;
        in_idle = 1'b1;
        cyc     = 0;
        repeat (3) step(1'b0, 1'b0, 16'h0000);
        repeat (12) step(1'b1, 1'b0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
